// File: rtl/tone_sample_writer.sv
// Square-wave tone generator with attack/sustain/release envelope and a one-entry sample buffer feeding the codec.
// Optional MIC_MIX_EN: saturating mix of the microphone sample into the tone.
module tone_sample_writer #(
  parameter int          HP_W         = 19,
  parameter int          SAMPLE_DIV   = 1042,
  parameter logic [31:0] AMP_MAX      = 32'd100000000,
  parameter logic [31:0] ATTACK_STEP  = 32'd1000000,
  parameter logic [31:0] RELEASE_STEP = 32'd500000
) (
  input  logic            CLOCK_50,
  input  logic            resetn,
  input  logic [HP_W-1:0] half_period,
  input  logic            note_on,
  input  logic            audio_out_allowed,
  input  logic [31:0]     left_channel_audio_in,
  output logic [31:0]     left_channel_audio_out,
  output logic [31:0]     right_channel_audio_out,
  output logic            write_audio_out,
  output logic [1:0]      env_state,
  output logic            overrun
);

  localparam int TW = $clog2(SAMPLE_DIV + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_t;

  env_t            state;
  env_t            state_next;
  logic [31:0]     amp;
  logic [31:0]     amp_next;
  logic [HP_W-1:0] osc_cnt;
  logic            phase;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [31:0]     sample_buf;
  logic            pending;
  logic            transfer;
  logic [31:0]     tone;
  logic [31:0]     sample_new;

  assign tick     = (tick_cnt == TW'(SAMPLE_DIV - 1));
  assign transfer = pending & audio_out_allowed;
  assign env_state = state;

  // Clamp tests are made on the headroom before the add/sub so amp never wraps.
  always_comb begin
    state_next = state;
    amp_next   = amp;
    if (tick) begin
      case (state)
        IDLE: begin
          amp_next = '0;
          if (note_on) state_next = ATTACK;
        end
        ATTACK: begin
          if (!note_on) begin
            state_next = RELEASE;
          end else if ((AMP_MAX - amp) <= ATTACK_STEP) begin
            amp_next   = AMP_MAX;
            state_next = SUSTAIN;
          end else begin
            amp_next = amp + ATTACK_STEP;
          end
        end
        SUSTAIN: begin
          amp_next = AMP_MAX;
          if (!note_on) state_next = RELEASE;
        end
        RELEASE: begin
          if (note_on) begin
            state_next = ATTACK;
          end else if (amp <= RELEASE_STEP) begin
            amp_next   = '0;
            state_next = IDLE;
          end else begin
            amp_next = amp - RELEASE_STEP;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign tone = (half_period == '0) ? 32'd0 : (phase ? amp_next : -amp_next);

`ifdef MIC_MIX_EN
  logic [32:0] mix_sum;
  assign mix_sum = {tone[31], tone} + {left_channel_audio_in[31], left_channel_audio_in};
  // Sign bits disagree only on overflow; the carry-out bit gives the direction.
  assign sample_new = (mix_sum[32] != mix_sum[31]) ?
                      (mix_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : mix_sum[31:0];
`else
  logic unused_mic;
  assign unused_mic = ^left_channel_audio_in;
  assign sample_new = tone;
`endif

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state                   <= IDLE;
      amp                     <= '0;
      osc_cnt                 <= '0;
      phase                   <= 1'b0;
      tick_cnt                <= '0;
      sample_buf              <= '0;
      pending                 <= 1'b0;
      write_audio_out         <= 1'b0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
      overrun                 <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      state    <= state_next;
      amp      <= amp_next;

      if (half_period == '0) begin
        osc_cnt <= '0;
        phase   <= 1'b0;
      end else if (osc_cnt >= half_period) begin
        osc_cnt <= '0;
        phase   <= ~phase;
      end else begin
        osc_cnt <= osc_cnt + HP_W'(1);
      end

      // Buffered sample moves to the output registers together with the strobe,
      // so a tick in the same cycle refills the buffer without disturbing the write.
      write_audio_out <= transfer;
      if (transfer) begin
        left_channel_audio_out  <= sample_buf;
        right_channel_audio_out <= sample_buf;
      end

      if (tick) begin
        sample_buf <= sample_new;
        pending    <= 1'b1;
        if (pending && !transfer) overrun <= 1'b1;
      end else if (transfer) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tone_sample_writer.sv
// Randomized scoreboard bench for tone_sample_writer: a tick-level reference model predicts every
// written sample, the envelope state and the overrun flag; a monitor compares at each strobe.
module tb_tone_sample_writer;

  localparam int DIV   = 10;
  localparam int AMAX  = 100;
  localparam int ASTEP = 40;
  localparam int RSTEP = 30;
  localparam int NCYC  = 4000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  hp = 8'd0;
  logic        note_on = 1'b0;
  logic        allowed = 1'b0;
  logic [31:0] mic = 32'd0;
  logic [31:0] left_out, right_out;
  logic        write_out;
  logic [1:0]  env_state;
  logic        overrun;

  always #5 clk = ~clk;

  tone_sample_writer #(
    .HP_W(8), .SAMPLE_DIV(DIV), .AMP_MAX(32'd100),
    .ATTACK_STEP(32'd40), .RELEASE_STEP(32'd30)
  ) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .half_period(hp),
    .note_on(note_on),
    .audio_out_allowed(allowed),
    .left_channel_audio_in(mic),
    .left_channel_audio_out(left_out),
    .right_channel_audio_out(right_out),
    .write_audio_out(write_out),
    .env_state(env_state),
    .overrun(overrun)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   done = 0;

  // Reference model state (spec-level quantities, advanced once per clock edge).
  int          m_cycle = 0;
  int          m_since_toggle = 0;
  bit          m_phase = 0;
  int          m_env = 0;
  longint      m_amp = 0;
  bit          m_pending = 0;
  bit          m_overrun = 0;
  logic [31:0] m_buf = 32'd0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_cycle = 0; m_since_toggle = 0; m_phase = 0; m_env = 0; m_amp = 0;
    m_pending = 0; m_overrun = 0; m_buf = 32'd0;
    q.delete();
  endfunction

  function automatic void model_step();
    bit     tick;
    bit     transfer;
    longint s;
    transfer = m_pending && allowed;
    if (transfer) q.push_back('{m_buf, cyc});
    tick = ((m_cycle % DIV) == DIV - 1);
    m_cycle++;
    if (tick) begin
      case (m_env)
        0: if (note_on) m_env = 1;
        1: if (!note_on) m_env = 3;
           else begin
             m_amp = (m_amp + ASTEP > AMAX) ? AMAX : m_amp + ASTEP;
             if (m_amp == AMAX) m_env = 2;
           end
        2: if (!note_on) m_env = 3;
        default: if (note_on) m_env = 1;
           else begin
             m_amp = (m_amp - RSTEP < 0) ? 0 : m_amp - RSTEP;
             if (m_amp == 0) m_env = 0;
           end
      endcase
      s = (hp == 0) ? 0 : (m_phase ? m_amp : -m_amp);
`ifdef MIC_MIX_EN
      s = s + longint'($signed(mic));
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      if (m_pending && !transfer) m_overrun = 1;
      m_buf = 32'(s);
      m_pending = 1;
    end else if (transfer) begin
      m_pending = 0;
    end
    // Phase flips once every hp+1 clocks; a shorter hp takes effect immediately.
    if (hp == 0) begin
      m_since_toggle = 0; m_phase = 0;
    end else if (m_since_toggle >= hp) begin
      m_since_toggle = 0; m_phase = !m_phase;
    end else begin
      m_since_toggle++;
    end
  endfunction

  function automatic logic [31:0] pick_mic();
    case ($urandom_range(3))
      0: return 32'h7FFF_FFF0;
      1: return 32'h8000_0010;
      2: return 32'($urandom_range(200)) - 32'd100;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] pick_hp();
    case ($urandom_range(5))
      0: return 8'd0;
      1: return 8'd2;
      2: return 8'd3;
      3: return 8'd5;
      4: return 8'd7;
      default: return 8'd12;
    endcase
  endfunction

  // Driver: inputs change on the falling edge; the model advances for the next rising edge.
  initial begin
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc = c;
      mic = pick_mic();
      if (c < 5 || (c >= 1540 && c < 1543) || (c >= 2400 && c < 2403)) begin
        resetn = 1'b0;
        model_reset();
        if (c == 4) begin note_on = 1'b1; hp = 8'd3; allowed = 1'b1; end
      end else begin
        resetn = 1'b1;
        if (c >= 1500 && c < 1540) begin
          allowed = 1'b0;                                   // back-pressure burst
        end else if (c >= 1543 && c < 1800) begin
          allowed = ((m_cycle % DIV) == DIV - 1);           // release buffer exactly on tick cycles
          if (c == 1543) begin note_on = 1'b1; hp = 8'd3; end
        end else begin
          allowed = ($urandom_range(7) != 0);
          if ($urandom_range(69) == 0) note_on = !note_on;
          if ($urandom_range(199) == 0) hp = pick_hp();
        end
        model_step();
      end
    end
    allowed = 1'b1;
    repeat (3 * DIV) begin
      @(negedge clk);
      cyc++;
      mic = pick_mic();
      model_step();
    end
    @(negedge clk);
    done = 1;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: samples shortly after each rising edge and pops the scoreboard on each strobe.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (done) break;
      check("env_state", 64'(env_state), 64'(m_env));
      check("overrun", 64'(overrun), 64'(m_overrun));
      if (!resetn) begin
        check("rst_write", 64'(write_out), 64'd0);
        check("rst_left", 64'(left_out), 64'd0);
        check("rst_right", 64'(right_out), 64'd0);
      end else if (write_out) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", 64'(write_out), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("strobe_cycle", 64'(cyc), 64'(e.due));
          check("left_sample", 64'(left_out), 64'(e.data));
          check("right_sample", 64'(right_out), 64'(e.data));
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        check("missing_strobe", 64'(write_out), 64'd1);
        void'(q.pop_front());
      end
    end
  end

endmodule
